// File: rtl/scan_flop_bank_if.sv
// Functional port and scan port of the scan flop bank.
// master drives stimulus, slave is the bank itself.
interface scan_flop_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q;
  logic              set_all;
  logic              shift_start;
  logic              update_en;
  logic              shift_i;
  logic              shift_o;
  logic              shift_busy;
  logic              shift_done;

  modport master (
    output we, addr, d, set_all,
    output shift_start, update_en, shift_i,
    input  q, shift_o, shift_busy, shift_done
  );

  modport slave (
    input  we, addr, d, set_all,
    input  shift_start, update_en, shift_i,
    output q, shift_o, shift_busy, shift_done
  );
endinterface

// File: rtl/scan_flop_bank.sv
// DEPTH x WIDTH register bank with a shared capture/shift/update
// scan chain; the functional port stays live during a scan.
module scan_flop_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic             flop_clk,
  input  logic             rst,
  scan_flop_bank_if.slave  bus
);
  localparam int L     = DEPTH * WIDTH;
  localparam int CNT_W = $clog2(L) + 1;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(L - 1);
  localparam logic [ADDR_W:0] NWORDS =
    (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE,
    DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [L-1:0]                shadow_q, shadow_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        upd_q, upd_d;
  logic                        addr_ok;

  assign addr_ok = {1'b0, bus.addr} < NWORDS;

  assign bus.q          = addr_ok ? mem_q[bus.addr]
                                  : '0;
  assign bus.shift_o    = shadow_q[L-1];
  assign bus.shift_busy = (state_q != IDLE);
  assign bus.shift_done = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    upd_d    = upd_q;
    mem_d    = mem_q;

    unique case (state_q)
      IDLE: begin
        // capture sees the words before any same-edge write
        if (bus.shift_start) begin
          state_d  = SHIFT;
          shadow_d = mem_q;
          cnt_d    = '0;
          upd_d    = bus.update_en;
        end
      end
      SHIFT: begin
        shadow_d = (shadow_q << 1) | L'(bus.shift_i);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = upd_q ? UPDATE : DONE;
        end
      end
      UPDATE: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == UPDATE) begin
      mem_d = shadow_q;
    end else if (bus.set_all) begin
      mem_d = '1;
    end else if (bus.we && addr_ok) begin
      mem_d[bus.addr] = bus.d;
    end
  end

  always_ff @(posedge flop_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mem_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
    end
  end
endmodule

// File: doc/scan_flop_bank.md
Name: scan_flop_bank

Overview:
- Parametrised successor to the single scan flop: a DEPTH x WIDTH bank of functional registers with one shared serial scan chain.
- A shadow chain captures all words, shifts them out while new data shifts in, then optionally writes back to the functional registers. JTAG-style capture/shift/update.
- The functional read/write port keeps operating during a scan, so the bank can be observed and loaded in-system without stopping the datapath.

Parameters:
- WIDTH, 8, bits per word.
- DEPTH, 4, number of words (>=1).
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH.
- L (localparam), DEPTH*WIDTH, scan chain length.
- CNT_W (localparam), $clog2(L)+1, shift counter width.

Ports:
- flop_clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  functional write enable.
- addr  in  ADDR_W  word select for read and write.
- d  in  WIDTH  write data.
- q  out  WIDTH  read data: word[addr], combinational.
- set_all  in  1  synchronous preset of every word to all-ones.
- shift_start  in  1  begin a scan; honoured only in IDLE.
- update_en  in  1  write the shadow back to the words at the end of a scan; sampled with shift_start.
- shift_i  in  1  serial scan input.
- shift_o  out  1  serial scan output; equals shadow[L-1].
- shift_busy  out  1  high whenever state != IDLE.
- shift_done  out  1  one-cycle pulse at the end of a scan.

Behaviour:
- Reset (rst=0, asynchronous):
  - All words = 0 and shadow = 0.
  - State = IDLE, counter = 0, latched update flag = 0.
  - shift_o = 0, shift_busy = 0, shift_done = 0.
  - Reset during a scan aborts it: no UPDATE, no shift_done.
- Shadow layout: shadow = {word[DEPTH-1], ..., word[0]}. Bit L-1 is word[DEPTH-1][WIDTH-1].
- FSM states: IDLE, SHIFT, UPDATE, DONE.
  - IDLE with shift_start=1: at the edge, shadow <= word concatenation, counter <= 0, flag <= update_en, next state SHIFT. Otherwise stay in IDLE.
  - SHIFT: every edge, shadow <= {shadow[L-2:0], shift_i} and counter increments. At the edge where counter == L-1 (the L-th shift), next state is UPDATE if flag=1, else DONE.
  - UPDATE: one cycle. At its edge, every word <= its shadow slice; next state DONE.
  - DONE: one cycle with shift_done=1; next state IDLE.
- Scan duration: shift_busy is high for L+1 cycles without update and L+2 cycles with update. The first valid shift_o bit is on the first SHIFT cycle and is MSB-first from word[DEPTH-1].
- Bit ordering: the first bit shifted in ends up at shadow[L-1], so data loads MSB-first into word[DEPTH-1].
- shift_start while busy: ignored; no restart and no effect on the flag.
- Word write priority per edge: UPDATE > set_all > we.
  - we during IDLE, SHIFT or DONE writes normally.
  - A we during SHIFT is overwritten later if the scan has update enabled.
  - we and set_all during the UPDATE cycle are dropped.
- Addressing: addr >= DEPTH makes a write a no-op and drives q = 0.
- Capture takes the word values before the same-edge write, so a write on the capture edge is not captured.

Test Plan:
- Reset, WIDTH=8, DEPTH=4 (L=32): release rst -> q=0x00 at addr 0..3, shift_o=0, shift_busy=0, shift_done=0.
- Write addr2 d=0xA5 -> q=0xA5 at addr2 the next cycle. Then set_all=1 with we=1 addr0 d=0x12 on the same edge -> all words 0xFF.
- Words 0x11/0x22/0x33/0x44 at addr 0..3, shift_start=1 with update_en=0 and shift_i=0:
  - shift_o over 32 cycles = 0x44, 0x33, 0x22, 0x11, MSB-first.
  - shift_busy high for 33 cycles; shift_done pulses at cycle 33.
  - Words are unchanged.
- Scan with update_en=1, shifting 0xDEADBEEF MSB-first -> after UPDATE, word3=0xDE, word2=0xAD, word1=0xBE, word0=0xEF; busy for 34 cycles.
- During an update scan, we to addr1 d=0x5A in SHIFT cycle 5 -> q=0x5A immediately, then replaced by the shadow value at UPDATE. we addr0 in the UPDATE cycle -> dropped.
- Start a scan, assert rst=0 at SHIFT cycle 10 -> state IDLE, words 0, no shift_done. A second shift_start issued mid-scan is ignored and the scan completes at the original cycle count.
